// File: rtl/neuron_accumulator.sv
// Dot-product accumulation stage: sign-extends a stream of signed terms and sums them through a
// selectable exact/approximate ADDER. Optional macro NEURON_ACC_SATURATE_EN clamps on overflow.

module neuron_acc_exact_add #(
    parameter int W     = 8,
    parameter int STYLE = 0
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o
);
    localparam int NBLK = (W + 3) / 4;

    logic [W-1:0] g;
    logic [W-1:0] p;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Carry out of bit hi given the carry entering bit lo, as a flat generate/propagate sum.
    function automatic logic la_carry(input logic [W-1:0] gv, input logic [W-1:0] pv,
                                      input logic cb, input int lo, input int hi);
        logic r;
        logic pp;
        r  = 1'b0;
        pp = 1'b1;
        for (int j = hi; j >= lo; j--) begin
            r  = r | (pp & gv[j]);
            pp = pp & pv[j];
        end
        return r | (pp & cb);
    endfunction

    genvar gi;
    genvar gk;
    generate
        if (STYLE == 1) begin : g_cla
            for (gi = 0; gi < NBLK; gi++) begin : g_blk
                localparam int LO = gi * 4;
                localparam int HI = (LO + 3 < W - 1) ? LO + 3 : W - 1;
                logic bcin;
                if (gi == 0) begin : g_first
                    assign bcin = cin_i;
                end else begin : g_next
                    assign bcin = la_carry(g, p, g_blk[gi-1].bcin, LO - 4, LO - 1);
                end
                for (gk = LO; gk <= HI; gk++) begin : g_bit
                    if (gk == LO) begin : g_lsb
                        assign sum_o[gk] = p[gk] ^ bcin;
                    end else begin : g_rest
                        assign sum_o[gk] = p[gk] ^ la_carry(g, p, bcin, LO, gk - 1);
                    end
                end
            end
        end else begin : g_rca
            for (gi = 0; gi < W; gi++) begin : g_fa
                logic ci;
                if (gi == 0) begin : g_first
                    assign ci = cin_i;
                end else begin : g_next
                    assign ci = g[gi-1] | (p[gi-1] & g_fa[gi-1].ci);
                end
                assign sum_o[gi] = p[gi] ^ ci;
            end
        end
    endgenerate
endmodule

module ADDER #(
    parameter int ADDERTYPE      = 0,
    parameter int SUBADDERTYPE   = 1,
    parameter int NB_APPROX_BITS = 2,
    parameter int BITWIDTH       = 8
) (
    input  logic [BITWIDTH-1:0] a_i,
    input  logic [BITWIDTH-1:0] b_i,
    output logic [BITWIDTH-1:0] sum_o
);
    localparam int K = (NB_APPROX_BITS >= BITWIDTH) ? BITWIDTH - 1 :
                       (NB_APPROX_BITS < 0) ? 0 : NB_APPROX_BITS;

    generate
        if (ADDERTYPE <= 1 || K == 0) begin : g_exact
            neuron_acc_exact_add #(
                .W    (BITWIDTH),
                .STYLE((ADDERTYPE <= 1) ? ADDERTYPE : SUBADDERTYPE)
            ) u_full (
                .a_i  (a_i),
                .b_i  (b_i),
                .cin_i(1'b0),
                .sum_o(sum_o)
            );
        end else begin : g_approx
            logic [K-1:0] lo_sum;
            logic         lo_c;
            logic         seen;

            // Lower K bits are approximated; the carry into the exact upper part depends on the variant.
            always_comb begin
                lo_sum = '0;
                lo_c   = 1'b0;
                seen   = 1'b0;
                case (ADDERTYPE)
                    2: begin
                        lo_sum = a_i[K-1:0] ^ b_i[K-1:0];
                        lo_c   = a_i[K-1] & b_i[K-1];
                    end
                    3: lo_sum = a_i[K-1:0] ^ b_i[K-1:0];
                    4: begin
                        for (int j = K - 1; j >= 0; j--) begin
                            if (seen || (a_i[j] & b_i[j])) begin
                                seen      = 1'b1;
                                lo_sum[j] = 1'b1;
                            end else begin
                                lo_sum[j] = a_i[j] ^ b_i[j];
                            end
                        end
                    end
                    5: begin
                        lo_sum = a_i[K-1:0] | b_i[K-1:0];
                        lo_c   = a_i[K-1] & b_i[K-1];
                    end
                    6: begin
                        lo_sum = b_i[K-1:0];
                        lo_c   = a_i[K-1];
                    end
                    default: lo_sum = '0;
                endcase
            end

            neuron_acc_exact_add #(
                .W    (BITWIDTH - K),
                .STYLE(SUBADDERTYPE)
            ) u_upper (
                .a_i  (a_i[BITWIDTH-1:K]),
                .b_i  (b_i[BITWIDTH-1:K]),
                .cin_i(lo_c),
                .sum_o(sum_o[BITWIDTH-1:K])
            );
            assign sum_o[K-1:0] = lo_sum;
        end
    endgenerate
endmodule

module neuron_accumulator #(
    parameter int ADDERTYPE      = 0,
    parameter int SUBADDERTYPE   = 1,
    parameter int NB_APPROX_BITS = 2,
    parameter int BITWIDTH       = 8,
    parameter int ACC_WIDTH      = 16,
    parameter int NB_TERMS       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ACC_WIDTH-1:0] bias,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITWIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf
);
    localparam int CW = $clog2(NB_TERMS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NB_TERMS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0]   add_a;
    logic [ACC_WIDTH-1:0]   add_b;
    logic [ACC_WIDTH-1:0]   add_sum;
    logic [ACC_WIDTH-1:0]   add_res;
    logic                   add_ovf;
    logic                   accept;

    // The first term of a dot product adds onto the bias instead of the stale accumulator.
    assign add_a = (state_q == S_IDLE) ? bias : acc_q;
    assign add_b = ACC_WIDTH'($signed(in_data));

    ADDER #(
        .ADDERTYPE     (ADDERTYPE),
        .SUBADDERTYPE  (SUBADDERTYPE),
        .NB_APPROX_BITS(NB_APPROX_BITS),
        .BITWIDTH      (ACC_WIDTH)
    ) u_adder (
        .a_i  (add_a),
        .b_i  (add_b),
        .sum_o(add_sum)
    );

    assign add_ovf = (add_a[ACC_WIDTH-1] == add_b[ACC_WIDTH-1]) &&
                     (add_sum[ACC_WIDTH-1] != add_a[ACC_WIDTH-1]);

`ifdef NEURON_ACC_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    assign add_res = add_ovf ? (add_a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : add_sum;
`else
    assign add_res = add_sum;
`endif

    assign accept   = in_valid & in_ready;
    assign out_data = acc_q;
    assign out_ovf  = ovf_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = add_res;
                    cnt_d   = CW'(1);
                    ovf_d   = add_ovf;
                    state_d = (NB_TERMS == 1) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d = add_res;
                    cnt_d = cnt_q + CW'(1);
                    ovf_d = ovf_q | add_ovf;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
